// File: rtl/fifo_rr_drain.sv
// Round-robin drain of NUM_PORTS FWFT FIFOs into one registered valid/ready stream, bursts of <= BURST_LEN words per grant.
// Latency: grant registered one edge after a port requests, first pop the cycle after, output valid one edge after the pop.
// Backpressure: a stalled output register (valid & !ready) blocks pops and holds grant, data and burst count.
module fifo_rr_drain #(
  parameter int NUM_PORTS  = 4,
  parameter int PORT_WIDTH = 2,
  parameter int DATA_WIDTH = 32,
  parameter int BURST_LEN  = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_PORTS-1:0]             fifo_empty_i,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]  fifo_dout_i,
  output logic [NUM_PORTS-1:0]             fifo_rd_en_o,
  input  logic [NUM_PORTS-1:0]             port_en_i,
  output logic [DATA_WIDTH-1:0]            m_data_o,
  output logic [PORT_WIDTH-1:0]            m_port_o,
  output logic                             m_valid_o,
  input  logic                             m_ready_i,
  output logic [NUM_PORTS-1:0]             grant_o,
  output logic                             busy_o
);

  typedef enum logic {IDLE, GRANT} state_e;

  localparam logic [7:0]            BURST_LAST = 8'(BURST_LEN - 1);
  localparam logic [PORT_WIDTH-1:0] LAST_INIT  = PORT_WIDTH'(NUM_PORTS - 1);

  state_e                  state_q, state_d;
  logic [NUM_PORTS-1:0]    grant_q, grant_d;
  logic [PORT_WIDTH-1:0]   gidx_q, gidx_d;
  logic [PORT_WIDTH-1:0]   last_q, last_d;
  logic [7:0]              cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic [PORT_WIDTH-1:0]   port_q, port_d;
  logic                    valid_q, valid_d;

  logic [NUM_PORTS-1:0]    req;
  logic                    req_g;
  logic                    can_load;
  logic                    move;
  logic [DATA_WIDTH-1:0]   sel_data;

  logic                    arb_found;
  logic [PORT_WIDTH-1:0]   arb_idx;
  logic [NUM_PORTS-1:0]    arb_oh;
  logic [NUM_PORTS-1:0]    oh_c;
  int                      cand;

  assign req      = ~fifo_empty_i & port_en_i;
  assign req_g    = |(req & grant_q);
  assign can_load = !valid_q || m_ready_i;
  assign move     = (state_q == GRANT) && can_load && req_g;

  // Head word of the granted port; grant_q is one-hot so an AND-OR mux suffices.
  always_comb begin
    sel_data = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      sel_data = sel_data | (fifo_dout_i[p*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{grant_q[p]}});
    end
  end

  // Round-robin pick: first requester after last_q, wrapping at NUM_PORTS (not 2**PORT_WIDTH).
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    arb_oh    = '0;
    oh_c      = '0;
    cand      = 0;
    for (int i = 1; i <= NUM_PORTS; i++) begin
      cand = int'(last_q) + i;
      if (cand >= NUM_PORTS) cand = cand - NUM_PORTS;
      oh_c = NUM_PORTS'(1) << cand;
      if (!arb_found && ((req & oh_c) != '0)) begin
        arb_found = 1'b1;
        arb_idx   = PORT_WIDTH'(cand);
        arb_oh    = oh_c;
      end
    end
  end

  // Pop strobe follows move combinationally; suppressed while in reset.
  always_comb begin
    fifo_rd_en_o = '0;
    if (move && !rst) fifo_rd_en_o = grant_q;
  end

  // Next-state: grant FSM, burst counter and output register.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    gidx_d  = gidx_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    port_d  = port_q;
    valid_d = valid_q;

    case (state_q)
      IDLE: begin
        if (arb_found) begin
          state_d = GRANT;
          grant_d = arb_oh;
          gidx_d  = arb_idx;
          last_d  = arb_idx;
          cnt_d   = '0;
        end
      end
      GRANT: begin
        if (move) cnt_d = cnt_q + 8'd1;
        // Release on the last word of the burst, or as soon as the port stops requesting.
        if ((move && (cnt_q == BURST_LAST)) || !req_g) begin
          state_d = IDLE;
          grant_d = '0;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase

    if (move) begin
      data_d  = sel_data;
      port_d  = gidx_q;
      valid_d = 1'b1;
    end else if (m_ready_i) begin
      valid_d = 1'b0;
    end
  end

  // State registers with synchronous reset; port 0 gets first priority after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      gidx_q  <= '0;
      last_q  <= LAST_INIT;
      cnt_q   <= '0;
      data_q  <= '0;
      port_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      gidx_q  <= gidx_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      port_q  <= port_d;
      valid_q <= valid_d;
    end
  end

  assign m_data_o  = data_q;
  assign m_port_o  = port_q;
  assign m_valid_o = valid_q;
  assign grant_o   = grant_q;
  assign busy_o    = (state_q == GRANT) || valid_q;

endmodule

// File: tb/tb_fifo_rr_drain.sv
// Bench for fifo_rr_drain: FWFT FIFO models feed the DUT, a scoreboard queue holds expected words.
// A negedge monitor pops and compares every accepted output word; directed tests drive the inputs.
module tb_fifo_rr_drain;
  localparam int NP = 4;
  localparam int PW = 2;
  localparam int DW = 32;
  localparam int BL = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [NP-1:0]    fifo_empty_i;
  logic [NP*DW-1:0] fifo_dout_i;
  logic [NP-1:0]    fifo_rd_en_o;
  logic [NP-1:0]    port_en_i = 4'hF;
  logic [DW-1:0]    m_data_o;
  logic [PW-1:0]    m_port_o;
  logic             m_valid_o;
  logic             m_ready_i = 1'b1;
  logic [NP-1:0]    grant_o;
  logic             busy_o;

  fifo_rr_drain #(.NUM_PORTS(NP), .PORT_WIDTH(PW), .DATA_WIDTH(DW), .BURST_LEN(BL)) dut (
    .clk(clk), .rst(rst),
    .fifo_empty_i(fifo_empty_i), .fifo_dout_i(fifo_dout_i), .fifo_rd_en_o(fifo_rd_en_o),
    .port_en_i(port_en_i),
    .m_data_o(m_data_o), .m_port_o(m_port_o), .m_valid_o(m_valid_o), .m_ready_i(m_ready_i),
    .grant_o(grant_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [PW-1:0] port;
    logic [DW-1:0] data;
  } exp_t;

  exp_t          exp_q[$];
  int            acc_q[$];
  int            n_chk = 0;
  int            n_err = 0;
  int            cyc = 0;
  logic          saw_g3 = 1'b0;

  // FWFT FIFO models: one storage row per port, pointers advance on pop.
  logic [DW-1:0] mem [NP][64];
  int            wr_ptr [NP];
  int            rd_ptr [NP];

  always_comb begin
    for (int p = 0; p < NP; p++) begin
      fifo_empty_i[p]         = (wr_ptr[p] == rd_ptr[p]);
      fifo_dout_i[p*DW +: DW] = mem[p][rd_ptr[p][5:0]];
    end
  end

  always @(posedge clk) begin
    for (int p = 0; p < NP; p++) begin
      if (fifo_rd_en_o[p] === 1'b1) rd_ptr[p] <= rd_ptr[p] + 1;
    end
  end

  function automatic logic [DW-1:0] mkw(input int p, input int k);
    return 32'hD000_0000 | DW'(p << 8) | DW'(k);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, wanted %0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  task automatic load(input int p, input int first, input int n);
    for (int k = 0; k < n; k++) begin
      mem[p][wr_ptr[p][5:0]] = mkw(p, first + k);
      wr_ptr[p] = wr_ptr[p] + 1;
    end
  endtask

  task automatic exp_push(input int p, input int first, input int n);
    exp_t e;
    for (int k = 0; k < n; k++) begin
      e.port = PW'(p);
      e.data = mkw(p, first + k);
      exp_q.push_back(e);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic idle_now();
    return (exp_q.size() == 0) && !busy_o && ((~fifo_empty_i & port_en_i) == '0);
  endfunction

  task automatic wait_idle(input string nm);
    int t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!idle_now() && t < 500);
    chk(nm, idle_now(), 1'b1);
  endtask

  task automatic wait_grant(input int p);
    int t = 0;
    while (grant_o[p] !== 1'b1 && t < 50) begin
      step();
      t++;
    end
    chk("grant_wait", grant_o[p], 1'b1);
  endtask

  // Monitor: every accepted word must match the head of the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    cyc = cyc + 1;
    if (!rst) begin
      chk("rd_en_onehot", ($countones(fifo_rd_en_o) <= 1), 1'b1);
      if (grant_o[3] === 1'b1) saw_g3 = 1'b1;
      if (m_valid_o && m_ready_i) begin
        acc_q.push_back(cyc);
        if (exp_q.size() == 0) begin
          n_chk++;
          n_err++;
          $display("FAIL unexpected_word: got port %0d data %0h, wanted none", m_port_o, m_data_o);
        end else begin
          e = exp_q.pop_front();
          chk("out_data", m_data_o, e.data);
          chk("out_port", m_port_o, e.port);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, wanted completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int expgap[5] = '{1, 1, 1, 2, 1};

    // 1: reset with all ports non-empty, then port 0 first
    for (int p = 0; p < NP; p++) load(p, 0, 1);
    for (int p = 0; p < NP; p++) exp_push(p, 0, 1);
    repeat (2) begin
      @(negedge clk);
      chk("rst_rd_en", fifo_rd_en_o, 4'b0000);
      chk("rst_valid", m_valid_o, 1'b0);
      chk("rst_grant", grant_o, 4'b0000);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    step();
    chk("first_grant", grant_o, 4'b0001);
    wait_idle("drain_t1");

    // 2: single port, 6 words -> burst of 4, bubble, 2
    step();
    acc_q.delete();
    exp_push(1, 0, 6);
    load(1, 0, 6);
    wait_idle("drain_t2");
    chk("t2_count", acc_q.size(), 6);
    if (acc_q.size() == 6) begin
      for (int i = 0; i < 5; i++) chk("t2_gap", acc_q[i+1] - acc_q[i], expgap[i]);
    end
    chk("t2_grant_idle", grant_o, 4'b0000);
    chk("t2_busy_idle", busy_o, 1'b0);

    // 3: ports 0 and 2 with 8 words each -> bursts 0,2,0,2
    step();
    saw_g3 = 1'b0;
    exp_push(0, 0, 4);
    exp_push(2, 0, 4);
    exp_push(0, 4, 4);
    exp_push(2, 4, 4);
    load(0, 0, 8);
    step();
    load(2, 0, 8);
    wait_idle("drain_t3");
    chk("t3_no_port3", saw_g3, 1'b0);

    // 4: backpressure for 3 cycles while the second word is held
    step();
    exp_push(3, 0, 4);
    load(3, 0, 4);
    wait_grant(3);
    step();
    step();
    m_ready_i = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("stall_rd_en", fifo_rd_en_o, 4'b0000);
      chk("stall_valid", m_valid_o, 1'b1);
      chk("stall_data", m_data_o, mkw(3, 1));
      chk("stall_port", m_port_o, 2'd3);
      step();
    end
    m_ready_i = 1'b1;
    wait_idle("drain_t4");

    // 5: disable port 0 after two pops; port 1 follows after one bubble
    step();
    exp_push(0, 0, 2);
    exp_push(1, 0, 3);
    load(0, 0, 6);
    load(1, 0, 3);
    wait_grant(0);
    step();
    step();
    port_en_i[0] = 1'b0;
    @(negedge clk);
    chk("mask_rd_en", fifo_rd_en_o, 4'b0000);
    step();
    chk("mask_release", grant_o, 4'b0000);
    step();
    chk("mask_next_grant", grant_o, 4'b0010);
    wait_idle("drain_t5");

    // 6: reset while a word is held in GRANT; word 2 is dropped, 3..5 stay in the FIFO
    step();
    exp_push(0, 3, 3);
    port_en_i[0] = 1'b1;
    wait_grant(0);
    step();
    rst = 1'b1;
    m_ready_i = 1'b0;
    @(negedge clk);
    chk("rst6_held_valid", m_valid_o, 1'b1);
    chk("rst6_rd_en", fifo_rd_en_o, 4'b0000);
    step();
    chk("rst6_valid", m_valid_o, 1'b0);
    chk("rst6_grant", grant_o, 4'b0000);
    rst = 1'b0;
    m_ready_i = 1'b1;
    wait_idle("drain_t6");

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/fifo_rr_drain.md
Name: fifo_rr_drain

Overview:
Round-robin read scheduler that drains NUM_PORTS first-word-fall-through FIFOs into one registered valid/ready output stream. Each grant lasts for a burst of at most BURST_LEN words, after which the grant is re-arbitrated. Every output word carries the index of its source port. The block sits between a bank of per-requester FWFT FIFOs and a single shared downstream consumer.

Parameters:
NUM_PORTS, 4, number of source FIFOs; legal range 2..16.
PORT_WIDTH, 2, width of the port index; NUM_PORTS <= 2**PORT_WIDTH is required.
DATA_WIDTH, 32, word width.
BURST_LEN, 4, maximum words transferred per grant; legal range 1..255.

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
fifo_empty_i  in  NUM_PORTS  per-port FWFT empty; bit p low means fifo_dout_i slice p is a valid word
fifo_dout_i  in  NUM_PORTS*DATA_WIDTH  per-port FWFT head word; port p occupies bits [p*DATA_WIDTH +: DATA_WIDTH]
fifo_rd_en_o  out  NUM_PORTS  per-port pop strobe; at most one bit high in any cycle
port_en_i  in  NUM_PORTS  per-port enable mask; a disabled port is never granted
m_data_o  out  DATA_WIDTH  output word
m_port_o  out  PORT_WIDTH  source port of m_data_o
m_valid_o  out  1  output word valid
m_ready_i  in  1  downstream accept
grant_o  out  NUM_PORTS  one-hot current grant; all zero when idle
busy_o  out  1  high while in GRANT state or while m_valid_o is high

Behaviour:
- Reset values: m_valid_o=0, m_data_o=0, m_port_o=0, grant_o=0, state=IDLE, burst count=0, last_grant=NUM_PORTS-1 (so port 0 has first priority). fifo_rd_en_o is forced to 0 while rst is high.
- Eligibility: req[p] = !fifo_empty_i[p] & port_en_i[p].
- Output register load condition: can_load = !m_valid_o | m_ready_i.

FSM with two states:
- IDLE:
  - If any req bit is set, select the first requesting port scanning last_grant+1, last_grant+2, ... with modulo NUM_PORTS wrap.
  - At the clock edge, register grant_o to that port (one-hot), set last_grant to it, clear the burst count, and go to GRANT.
  - No pops occur in IDLE.
- GRANT (granted port g):
  - move = can_load & req[g].
  - fifo_rd_en_o[g] = move. This is combinational, with no added latency; FWFT semantics make the head word valid in the same cycle.
  - On move: m_data_o <= fifo_dout_i[g], m_port_o <= g, m_valid_o <= 1, burst count += 1.
  - Release to IDLE (grant_o <= 0) when either:
    - move occurs and the burst count equals BURST_LEN-1 (the last word of the burst), or
    - !req[g], i.e. the port went empty or was disabled.
  - Downstream stall (!can_load with req[g] high) holds the grant, the data and the count unchanged; no pop occurs.
- Output register in any state: if no move this cycle and m_ready_i is high, then m_valid_o <= 0. m_data_o and m_port_o hold their values while m_valid_o=1 and m_ready_i=0.
- Throughput: one word per cycle within a burst. Each re-arbitration costs exactly one IDLE bubble cycle.
- Latency: a port's empty flag falls before edge N. Grant is registered at edge N. The first pop happens in the following cycle. m_valid_o rises after edge N+1.
- A single requester that is always non-empty receives back-to-back bursts of BURST_LEN words, each separated by one bubble.
- Port disabled mid-burst: release happens in the same cycle that req[g] drops. Words already in the output register are still delivered.
- rst asserted mid-burst: all state returns to reset values at the next edge, and any held output word is dropped. Words still in the FIFOs are untouched.
- Arbitration always wraps modulo NUM_PORTS, even when NUM_PORTS < 2**PORT_WIDTH. Index values >= NUM_PORTS are never produced.

Test Plan:
1. Reset check: hold rst for 2 cycles with all ports non-empty. Required: fifo_rd_en_o=0, m_valid_o=0, grant_o=0 throughout. After rst drops, port 0 is granted first.
2. Single port, burst boundary: BURST_LEN=4, only port 1 with 6 words, m_ready_i=1. Required: 4 words on consecutive cycles with m_port_o=1, then one bubble, then the remaining 2 words, then grant_o=0 and busy_o=0.
3. Round-robin fairness: ports 0 and 2 each hold 8 words, m_ready_i=1. Required: burst order 0,2,0,2, each burst 4 words, word order preserved within each port, port 3 never granted.
4. Backpressure: m_ready_i low for 3 cycles during the second word of a burst. Required: fifo_rd_en_o=0 and m_data_o/m_port_o stable during the stall, no word lost or duplicated, burst still totals 4 words.
5. Mask mid-burst: clear port_en_i[g] after 2 words. Required: no further pops from g, release in that cycle, next requesting port granted after one bubble, and the 2 popped words are delivered.
6. Reset mid-burst: assert rst while m_valid_o=1 in GRANT. Required: next cycle m_valid_o=0, grant_o=0, and the rd_en bit for that port is low during rst.
